// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent edge-triggered JK flip-flops with synchronous,
// active-high reset; q_n is the combinational complement of the stored state.
module jk_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Terms are split per JK case so that set/clear resolve an unknown q,
    // while hold and toggle carry an unknown q forward.
    always_comb begin
        q_d = ( j & ~k)
            | ( j &  k & ~q_q)
            | (~j & ~k &  q_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign q_n = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench for jk_flip_flop: a 1-bit default instance and a 4-bit
// instance with a non-zero reset value, checked with immediate assertions.
module tb_jk_flip_flop;

    logic       clk;
    logic       reset;
    logic       j1, k1;
    logic       q1, qn1;
    logic [3:0] j4, k4;
    logic [3:0] q4, qn4;

    int checks   = 0;
    int failures = 0;

    jk_flip_flop dut1 (
        .clk   (clk),
        .reset (reset),
        .j     (j1),
        .k     (k1),
        .q     (q1),
        .q_n   (qn1)
    );

    jk_flip_flop #(
        .WIDTH     (4),
        .RESET_VAL (4'b1010)
    ) dut4 (
        .clk   (clk),
        .reset (reset),
        .j     (j4),
        .k     (k4),
        .q     (q4),
        .q_n   (qn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic m_q;
    int   t;

    initial begin
        reset = 1'b0;
        j1 = 1'b0; k1 = 1'b0;
        j4 = 4'b0000; k4 = 4'b0000;
        #1;

        // Reset has priority over j=k=1
        reset = 1'b1; j1 = 1'b1; k1 = 1'b1;
        edge_step();
        chk("rst_q", {3'b0, q1}, 4'b0000);
        chk("rst_qn", {3'b0, qn1}, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk($sformatf("rst_hold%0d", i), {3'b0, q1}, 4'b0000);
        end

        // Set, hold, clear
        reset = 1'b0; j1 = 1'b1; k1 = 1'b0;
        edge_step();
        chk("set", {3'b0, q1}, 4'b0001);
        chk("set_qn", {3'b0, qn1}, 4'b0000);
        j1 = 1'b0; k1 = 1'b0;
        edge_step();
        chk("hold0", {3'b0, q1}, 4'b0001);
        edge_step();
        chk("hold1", {3'b0, q1}, 4'b0001);
        j1 = 1'b0; k1 = 1'b1;
        edge_step();
        chk("clear", {3'b0, q1}, 4'b0000);

        // Toggle from 0: 1,0,1,0
        j1 = 1'b1; k1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            chk($sformatf("toggle%0d", i), {3'b0, q1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        end

        // Reset pulse entirely between edges is ignored
        j1 = 1'b1; k1 = 1'b0;
        edge_step();
        chk("preset", {3'b0, q1}, 4'b0001);
        j1 = 1'b0; k1 = 1'b0;
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        edge_step();
        chk("glitch_rst", {3'b0, q1}, 4'b0001);

        // Reset at an edge while toggling
        j1 = 1'b1; k1 = 1'b1;
        edge_step();
        chk("tog_a", {3'b0, q1}, 4'b0000);
        edge_step();
        chk("tog_b", {3'b0, q1}, 4'b0001);
        reset = 1'b1;
        edge_step();
        chk("tog_rst", {3'b0, q1}, 4'b0000);
        reset = 1'b0;

        // Free-running pattern over 200 ns of a notional timeline whose rising
        // edges sit at t=5+10n; inputs take the value held just before each edge.
        m_q = q1;
        for (int n = 0; n < 20; n++) begin
            t = 5 + 10 * n;
            reset = ((t - 1) / 10) % 2 == 1;
            j1    = ((t - 1) / 15) % 2 == 1;
            k1    = ((t - 1) / 20) % 2 == 1;
            if (reset)          m_q = 1'b0;
            else if (j1 && k1)  m_q = ~m_q;
            else if (j1)        m_q = 1'b1;
            else if (k1)        m_q = 1'b0;
            edge_step();
            chk($sformatf("free_q_t%0d", t), {3'b0, q1}, {3'b0, m_q});
            chk($sformatf("free_qn_t%0d", t), {3'b0, qn1}, {3'b0, ~m_q});
        end

        // 4-bit instance with RESET_VAL=1010
        reset = 1'b1; j4 = 4'b1111; k4 = 4'b0000;
        edge_step();
        chk("w4_rst", q4, 4'b1010);
        chk("w4_rst_qn", qn4, 4'b0101);
        reset = 1'b0;
        // bit3 set, bit2 toggle 0->1, bit1 clear, bit0 hold 0
        j4 = 4'b1100; k4 = 4'b0110;
        edge_step();
        chk("w4_mix1", q4, 4'b1100);
        chk("w4_mix1_qn", qn4, 4'b0011);
        // bit3 hold 1, bit2 clear, bit1 set, bit0 toggle 0->1
        j4 = 4'b0011; k4 = 4'b0101;
        edge_step();
        chk("w4_mix2", q4, 4'b1011);
        // all toggle
        j4 = 4'b1111; k4 = 4'b1111;
        edge_step();
        chk("w4_tog", q4, 4'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
